// File: rtl/muldiv_hilo_unit.sv
// Iterative radix-2 multiply/divide engine with the architectural HI/LO registers.
// Decodes R-format HI/LO instructions and stalls the pipeline while the engine is busy.
module muldiv_hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic               div_zero,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(16);
  localparam logic [FUNCT_W-1:0] F_MTHI  = FUNCT_W'(17);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(18);
  localparam logic [FUNCT_W-1:0] F_MTLO  = FUNCT_W'(19);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(24);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(25);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(26);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(27);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc;      // product high half / partial remainder
  logic [WIDTH-1:0]   q;        // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]   m;        // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   rs_orig;
  logic               op_div, neg_q, neg_r, dz;

  logic dec, is_mfhi, is_mthi, is_mflo, is_mtlo, is_md, op_signed, op_is_div;
  assign dec       = valid && (alu_op == 2'b10);
  assign is_mfhi   = dec && (funct == F_MFHI);
  assign is_mthi   = dec && (funct == F_MTHI);
  assign is_mflo   = dec && (funct == F_MFLO);
  assign is_mtlo   = dec && (funct == F_MTLO);
  assign is_md     = dec && ((funct == F_MULT) || (funct == F_MULTU) ||
                             (funct == F_DIV)  || (funct == F_DIVU));
  assign op_signed = (funct == F_MULT) || (funct == F_DIV);
  assign op_is_div = (funct == F_DIV)  || (funct == F_DIVU);

  assign stall        = busy && (is_mfhi || is_mthi || is_mflo || is_mtlo || is_md);
  assign result_valid = !busy && (is_mfhi || is_mflo);
  assign result       = !result_valid ? '0 : (is_mfhi ? hi : lo);

  logic [WIDTH-1:0]   rs_abs, rt_abs;
  assign rs_abs = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_abs = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mul_sum  = '0;
    div_sh   = '0;
    div_diff = '0;
    mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    div_sh   = {acc, q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m};
    prod_fix = neg_q ? -{acc, q} : {acc, q};
    quo_fix  = neg_q ? -q : q;
    rem_fix  = neg_r ? -acc : acc;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      rs_orig  <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (is_mthi) hi <= rs_val;
          if (is_mtlo) lo <= rs_val;
          if (is_md) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            cnt     <= CNT_W'(WIDTH);
            acc     <= '0;
            q       <= op_is_div ? rs_abs : rt_abs;
            m       <= op_is_div ? rt_abs : rs_abs;
            rs_orig <= rs_val;
            op_div  <= op_is_div;
            neg_q   <= op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_r   <= op_signed && rs_val[WIDTH-1];
            dz      <= op_is_div && (rt_val == '0);
          end
        end
        S_RUN: begin
          if (op_div) begin
            // Restoring step: keep the trial difference only if it did not go negative.
            if (!div_diff[WIDTH]) begin
              acc <= div_diff[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_sh[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (!op_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (dz) begin
            hi <= rs_orig;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done     <= 1'b1;
          div_zero <= dz;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Parametrised iterative multiply/divide engine, plus the HI/LO register file, for the MIPS datapath.
- Sits beside the ALU. It decodes the R-format funct field whenever ALUOp==2'b10 and takes mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- Runs mult/div over WIDTH+1 cycles and raises a stall to the hazard logic when an HI/LO access collides with a busy engine.
- Extends the combinational ALU control path with multi-cycle operations and architectural HI/LO state.

Parameters:
- WIDTH, 32, operand, HI and LO width (>=2).
- FUNCT_W, 6, width of the funct field.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  instruction presented this cycle.
- alu_op  in  2  ALUOp from the control unit; only 2'b10 is acted on.
- funct  in  FUNCT_W  funct field of the instruction.
- rs_val  in  WIDTH  rs operand (multiplicand/dividend, or source for mthi/mtlo).
- rt_val  in  WIDTH  rt operand (multiplier/divisor).
- busy  out  1  engine occupied (RUN or FIX).
- stall  out  1  pipeline must hold the current instruction.
- done  out  1  one-cycle pulse: HI/LO now hold the mult/div result.
- div_zero  out  1  one-cycle pulse with done when the divisor was 0.
- result  out  WIDTH  mfhi/mflo read data.
- result_valid  out  1  result is valid this cycle.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.

Behaviour:
- Decode, active only when valid=1 and alu_op=2'b10:
  - funct 16 = mfhi, 17 = mthi, 18 = mflo, 19 = mtlo.
  - funct 24 = mult, 25 = multu, 26 = div, 27 = divu.
  - Any other funct or alu_op: ignored, stall=0, result_valid=0.
- Reset (asynchronous, any state including mid-operation):
  - State returns to IDLE; counter=0.
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - The partial result is discarded.
- FSM IDLE -> RUN -> FIX -> IDLE:
  - IDLE: a mult/div accepted at a clock edge latches the operands and a signed flag, captures absolute values (signed ops only), and sets counter=WIDTH.
  - RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). The counter decrements; the step with counter==1 moves the FSM to FIX. RUN lasts exactly WIDTH cycles.
  - FIX: applies sign correction, writes HI/LO at the end of the cycle, goes to IDLE.
    - Signed multiply: negate the 2W product if the operand signs differ.
    - Signed divide: quotient is negative if the signs differ; remainder takes the dividend's sign.
- Latency:
  - Accept at edge E0; RUN spans E1..EW; FIX ends at E(W+1).
  - The new hi/lo and done=1 are visible in the cycle after E(W+1). done is registered and lasts exactly one cycle.
- busy is registered: 1 in RUN and FIX, 0 in IDLE.
- Results:
  - mult/multu: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2W-bit product.
  - div/divu: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend (original rs_val), div_zero pulses with done. Latency is unchanged.
- Signed overflow (min / -1): LO = min (100..0), HI = 0. Must fall out of the unsigned magnitude path; no special case.
- Collisions while busy=1 with a decoded HI/LO instruction (mfhi, mflo, mthi, mtlo, mult, div, multu, divu):
  - stall=1, combinationally; the instruction is not accepted, and nothing is written or read.
  - stall drops in the first cycle busy=0. The held instruction executes in that cycle, seeing the updated HI/LO.
- mfhi/mflo with busy=0: result = hi or lo respectively (combinational from the registers), result_valid=1, stall=0.
- mthi/mtlo with busy=0: hi (or lo) <= rs_val at the clock edge; no stall.
- An instruction presented in the same cycle as done (busy already 0) is accepted normally.
- result is 0 whenever result_valid=0.

Test Plan:
- WIDTH=32, mult rs=0xFFFFFFFD (-3), rt=7 -> busy=1 for 33 cycles; done pulses 33 cycles after accept with hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat as multu -> hi=0x00000006, lo=0xFFFFFFEB.
- divu 100/7 -> lo=14, hi=2. div -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- div rs=0x1234, rt=0 -> done and div_zero both pulse after 33 cycles; lo=0xFFFFFFFF, hi=0x1234.
- Issue mult, then hold mflo valid from the next cycle:
  - stall=1 every cycle while busy=1 and result_valid=0.
  - In the first busy=0 cycle: stall=0, result_valid=1, result = the new lo.
  - A non-R instruction (alu_op=00) during busy -> stall=0.
- mtlo rs=0xA5A5A5A5, then mflo -> result=0xA5A5A5A5; hi unchanged.
- Start div, assert rst_n=0 at RUN cycle 10 -> busy, hi, lo, done, div_zero all 0 immediately (asynchronous). After release, a fresh multu 3*5 gives lo=15, hi=0. Also rerun one case with WIDTH=8: multu 0xFF*0xFF -> hi=0xFE, lo=0x01, with latency 9.
